mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/jericalla_pkg.sv | 18 +
 rtl/arb_lat_counter.sv | 29 ++
 rtl/mem_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/jericalla_pkg.sv
// Shared definitions for the memory arbiter: FSM encoding, default timing
// parameters and counter widths.
package jericalla_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_RD_DONE = 2'd2
  } arb_state_e;

  localparam int unsigned RD_LAT_DEF     = 1;
  localparam int unsigned STARVE_MAX_DEF = 4;

  // Sized for the largest legal RD_LAT (7) and STARVE_MAX (15).
  localparam int unsigned LAT_W    = 3;
  localparam int unsigned STARVE_W = 4;

endpackage

// File: rtl/arb_lat_counter.sv
// RAM read-latency down-counter: loaded on read acceptance, decremented while
// the arbiter waits, done when it reaches zero.
module arb_lat_counter
  import jericalla_pkg::*;
#(
  parameter int unsigned LOAD_VAL = RD_LAT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic dec_i,
  output logic done_o
);

  logic [LAT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= LAT_W'(LOAD_VAL);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between the pipeline memory stage and a loader,
// with starvation-based loader priority and a fixed read latency.
module mem_arbiter
  import jericalla_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned RD_LAT     = RD_LAT_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_uc_e_read_ram,
  input  logic              i_uc_e_write_ram,
  input  logic [ADDR_W-1:0] i_address_ram,
  input  logic [DATA_W-1:0] i_din_ram,
  output logic              o_stall,
  output logic [DATA_W-1:0] o_dout,
  output logic              o_dout_valid,
  input  logic              i_ld_req,
  input  logic              i_ld_we,
  input  logic [ADDR_W-1:0] i_ld_address,
  input  logic [DATA_W-1:0] i_ld_din,
  output logic              o_ld_gnt,
  output logic [DATA_W-1:0] o_ld_dout,
  output logic              o_ld_valid,
  output logic              o_ram_re,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_address,
  output logic [DATA_W-1:0] o_ram_din,
  input  logic [DATA_W-1:0] i_ram_dout,
  output logic              o_err
);

  arb_state_e          state_q;
  logic                owner_ld_q;
  logic [STARVE_W-1:0] starve_q;
  logic                pipe_req, ld_prio, pipe_acc, ld_acc, rd_acc, lat_done;

  always_comb begin
    pipe_req = i_uc_e_read_ram | i_uc_e_write_ram;
    ld_prio  = (starve_q == STARVE_W'(STARVE_MAX));
    pipe_acc = !rst && (state_q == ST_IDLE) && pipe_req && !(i_ld_req && ld_prio);
    ld_acc   = !rst && (state_q == ST_IDLE) && i_ld_req && !pipe_acc;
    rd_acc   = (pipe_acc && !i_uc_e_write_ram) || (ld_acc && !i_ld_we);
    o_ld_gnt = ld_acc;
    // In RD_DONE the pipeline read being completed must be released, but a
    // pipeline request waiting behind a loader read stays held.
    o_stall = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_IDLE:    o_stall = pipe_req && !(pipe_acc && i_uc_e_write_ram);
        ST_RD_WAIT: o_stall = pipe_req || !owner_ld_q;
        ST_RD_DONE: o_stall = pipe_req && owner_ld_q;
        default:    o_stall = 1'b0;
      endcase
    end
  end

  arb_lat_counter #(
    .LOAD_VAL (RD_LAT)
  ) u_lat (
    .clk    (clk),
    .rst    (rst),
    .load_i (rd_acc),
    .dec_i  (state_q == ST_RD_WAIT),
    .done_o (lat_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      owner_ld_q    <= 1'b0;
      starve_q      <= '0;
      o_err         <= 1'b0;
      o_ram_re      <= 1'b0;
      o_ram_we      <= 1'b0;
      o_ram_address <= '0;
      o_ram_din     <= '0;
      o_dout        <= '0;
      o_dout_valid  <= 1'b0;
      o_ld_dout     <= '0;
      o_ld_valid    <= 1'b0;
    end else begin
      o_ram_re     <= 1'b0;
      o_ram_we     <= 1'b0;
      o_dout_valid <= 1'b0;
      o_ld_valid   <= 1'b0;
      if (i_uc_e_read_ram && i_uc_e_write_ram) o_err <= 1'b1;
      if (ld_acc) starve_q <= '0;
      else if (i_ld_req && !ld_prio) starve_q <= starve_q + 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (pipe_acc) begin
            o_ram_address <= i_address_ram;
            o_ram_din     <= i_din_ram;
            o_ram_we      <= i_uc_e_write_ram;
            o_ram_re      <= !i_uc_e_write_ram;
            owner_ld_q    <= 1'b0;
          end else if (ld_acc) begin
            o_ram_address <= i_ld_address;
            o_ram_din     <= i_ld_din;
            o_ram_we      <= i_ld_we;
            o_ram_re      <= !i_ld_we;
            owner_ld_q    <= 1'b1;
          end
          if (rd_acc) state_q <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (lat_done) begin
            if (owner_ld_q) begin
              o_ld_dout  <= i_ram_dout;
              o_ld_valid <= 1'b1;
            end else begin
              o_dout       <= i_ram_dout;
              o_dout_valid <= 1'b1;
            end
            state_q <= ST_RD_DONE;
          end
        end
        ST_RD_DONE: state_q <= ST_IDLE;
        default:    state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
